multi_modport_bus: RTL and testbench



---
 rtl/multi_modport_bus.sv | 95 +++++++++
 tb/tb_multi_modport_bus.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/multi_modport_bus.sv
`default_nettype none
// ============================================================================
// Module   : multi_modport_bus
// Purpose  : Single-clock 64-bit word memory target with a monitor tap.
//            A CPU-side master issues byte-addressed whole-word reads and
//            writes. Every access is acknowledged one cycle later, with no
//            wait states. A read-only monitor port mirrors each accepted
//            write for debug and scoreboarding.
// Ports    : clk, rst_n                 - clock, async active-low reset
//            addr, data_write           - CPU byte address / write data
//            write_en, read_en          - CPU request strobes
//            data_read, ack             - registered read data / acknowledge
//            mon_wr_valid               - one-cycle pulse per accepted write
//            mon_addr, mon_data         - address/data of last accepted write
//            mon_wr_count               - wrapping count of accepted writes
// Revision : 1.0 - initial release
// ============================================================================
module multi_modport_bus #(
    parameter int DEPTH = 1024,
    parameter int AW    = 32,
    parameter int DW    = 64
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic [AW-1:0] addr,
    input  wire logic [DW-1:0] data_write,
    input  wire logic          write_en,
    input  wire logic          read_en,
    output logic      [DW-1:0] data_read,
    output logic               ack,
    output logic               mon_wr_valid,
    output logic      [AW-1:0] mon_addr,
    output logic      [DW-1:0] mon_data,
    output logic      [31:0]   mon_wr_count
);

    localparam int IW = $clog2(DEPTH);

    // Storage is deliberately left out of reset so it can map onto a RAM.
    logic [DW-1:0] r_mem [DEPTH];

    logic [DW-1:0] r_data_read;
    logic          r_ack;
    logic          r_mon_valid;
    logic [AW-1:0] r_mon_addr;
    logic [DW-1:0] r_mon_data;
    logic [31:0]   r_wr_count;

    // Byte lane bits [2:0] are dropped and everything above the index is
    // ignored, so addresses alias every DEPTH*8 bytes.
    logic [IW-1:0] w_idx;
    assign w_idx = addr[3 +: IW];

    // Writes are suppressed while reset is held so that contents survive a
    // reset pulse even if the master keeps write_en asserted.
    always_ff @(posedge clk) begin
        if (rst_n && write_en) begin
            r_mem[w_idx] <= data_write;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_read <= '0;
            r_ack       <= 1'b0;
            r_mon_valid <= 1'b0;
            r_mon_addr  <= '0;
            r_mon_data  <= '0;
            r_wr_count  <= '0;
        end else begin
            // A combined read+write yields one ack, not two.
            r_ack       <= write_en | read_en;
            r_mon_valid <= write_en;
            // Non-blocking semantics give read-before-write on a collision:
            // this samples the word as it was before the same-edge write.
            if (read_en) begin
                r_data_read <= r_mem[w_idx];
            end
            if (write_en) begin
                r_mon_addr <= addr;
                r_mon_data <= data_write;
                r_wr_count <= r_wr_count + 32'd1;
            end
        end
    end

    assign data_read    = r_data_read;
    assign ack          = r_ack;
    assign mon_wr_valid = r_mon_valid;
    assign mon_addr     = r_mon_addr;
    assign mon_data     = r_mon_data;
    assign mon_wr_count = r_wr_count;

endmodule
`default_nettype wire

// File: tb/tb_multi_modport_bus.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_modport_bus
// Purpose  : Directed self-checking bench for multi_modport_bus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_modport_bus;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic [63:0] data_write;
    logic        write_en;
    logic        read_en;
    logic [63:0] data_read;
    logic        ack;
    logic        mon_wr_valid;
    logic [31:0] mon_addr;
    logic [63:0] mon_data;
    logic [31:0] mon_wr_count;

    int n_total = 0;
    int n_bad   = 0;

    multi_modport_bus #(
        .DEPTH (1024),
        .AW    (32),
        .DW    (64)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .addr         (addr),
        .data_write   (data_write),
        .write_en     (write_en),
        .read_en      (read_en),
        .data_read    (data_read),
        .ack          (ack),
        .mon_wr_valid (mon_wr_valid),
        .mon_addr     (mon_addr),
        .mon_data     (mon_data),
        .mon_wr_count (mon_wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%016h expected=0x%016h", tag, got, exp);
        end
    endtask

    // One request cycle: drive, take the edge, settle, return strobes to idle.
    task automatic step(input logic we, input logic re, input logic [31:0] a, input logic [63:0] d);
        write_en   = we;
        read_en    = re;
        addr       = a;
        data_write = d;
        @(posedge clk);
        #1;
        write_en = 1'b0;
        read_en  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; addr = '0; data_write = '0; write_en = 1'b0; read_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack",   {63'd0, ack}, 64'd0);
        check("rst_rdata", data_read, 64'd0);
        check("rst_mvld",  {63'd0, mon_wr_valid}, 64'd0);
        check("rst_maddr", {32'd0, mon_addr}, 64'd0);
        check("rst_mdata", mon_data, 64'd0);
        check("rst_mcnt",  {32'd0, mon_wr_count}, 64'd0);
        @(negedge clk); rst_n = 1'b1;

        // Seed word 0, then hold reset with write_en asserted.
        @(negedge clk);
        step(1'b1, 1'b0, 32'h0, 64'hDEAD_BEEF_0000_0001);
        check("seed_ack",  {63'd0, ack}, 64'd1);
        check("seed_mvld", {63'd0, mon_wr_valid}, 64'd1);
        check("seed_mcnt", {32'd0, mon_wr_count}, 64'd1);
        @(negedge clk);
        rst_n = 1'b0; write_en = 1'b1; addr = 32'h0; data_write = 64'hFFFF_FFFF_FFFF_FFFF;
        repeat (5) @(posedge clk);
        #1;
        check("rsthold_ack",  {63'd0, ack}, 64'd0);
        check("rsthold_mcnt", {32'd0, mon_wr_count}, 64'd0);
        check("rsthold_mvld", {63'd0, mon_wr_valid}, 64'd0);
        @(negedge clk); write_en = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        step(1'b0, 1'b1, 32'h0, 64'd0);
        check("rsthold_keep", data_read, 64'hDEAD_BEEF_0000_0001);
        check("rd0_ack",      {63'd0, ack}, 64'd1);
        check("rd0_mvld",     {63'd0, mon_wr_valid}, 64'd0);

        // Write then read back.
        step(1'b1, 1'b0, 32'h40, 64'h1122_3344_5566_7788);
        check("wr40_ack",   {63'd0, ack}, 64'd1);
        check("wr40_maddr", {32'd0, mon_addr}, 64'h40);
        check("wr40_mdata", mon_data, 64'h1122_3344_5566_7788);
        check("wr40_mcnt",  {32'd0, mon_wr_count}, 64'd1);
        step(1'b0, 1'b1, 32'h40, 64'd0);
        check("rd40_ack",   {63'd0, ack}, 64'd1);
        check("rd40_data",  data_read, 64'h1122_3344_5566_7788);
        check("rd40_mvld",  {63'd0, mon_wr_valid}, 64'd0);
        check("rd40_maddr", {32'd0, mon_addr}, 64'h40);

        // Aliasing: 0x200D -> word (0x200D>>3)&0x3FF = 1, same as 0x8.
        step(1'b1, 1'b0, 32'h8, 64'hA5);
        step(1'b0, 1'b1, 32'h200D, 64'd0);
        check("alias_data",  data_read, 64'hA5);
        check("alias_maddr", {32'd0, mon_addr}, 64'h8);
        check("alias_mcnt",  {32'd0, mon_wr_count}, 64'd2);

        // Simultaneous read and write at word 3.
        step(1'b1, 1'b0, 32'h18, 64'h1);
        step(1'b1, 1'b1, 32'h18, 64'h2);
        check("rw_old",  data_read, 64'h1);
        check("rw_ack",  {63'd0, ack}, 64'd1);
        check("rw_mcnt", {32'd0, mon_wr_count}, 64'd4);
        @(posedge clk); #1;
        check("rw_ack1", {63'd0, ack}, 64'd0);
        check("rw_hold", data_read, 64'h1);
        @(negedge clk);
        step(1'b0, 1'b1, 32'h18, 64'd0);
        check("rw_new", data_read, 64'h2);

        // Streaming: 8 back-to-back writes at 0x0..0x1C, step 4.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 32'(i * 4), 64'(32'h100 + i));
            check("strm_ack",  {63'd0, ack}, 64'd1);
            check("strm_mvld", {63'd0, mon_wr_valid}, 64'd1);
        end
        check("strm_mcnt",  {32'd0, mon_wr_count}, 64'd12);
        check("strm_maddr", {32'd0, mon_addr}, 64'h1C);
        check("strm_mdata", mon_data, 64'h107);
        @(posedge clk); #1;
        check("strm_end_ack",  {63'd0, ack}, 64'd0);
        check("strm_end_mvld", {63'd0, mon_wr_valid}, 64'd0);
        @(negedge clk);
        step(1'b0, 1'b1, 32'h18, 64'd0);
        check("strm_rd18", data_read, 64'h107);

        // Counter wrap.
        @(negedge clk);
        force dut.r_wr_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_wr_count;
        step(1'b1, 1'b0, 32'h80, 64'h55);
        check("wrap_mcnt", {32'd0, mon_wr_count}, 64'd0);

        // Reset asserted in the cycle after a read request.
        @(negedge clk);
        step(1'b0, 1'b1, 32'h40, 64'd0);
        check("mid_ack_pre",  {63'd0, ack}, 64'd1);
        check("mid_data_pre", data_read, 64'h1122_3344_5566_7788);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_ack",   {63'd0, ack}, 64'd0);
        check("mid_data",  data_read, 64'd0);
        check("mid_maddr", {32'd0, mon_addr}, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        step(1'b0, 1'b1, 32'h80, 64'd0);
        check("post_rst_rd", data_read, 64'h55);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
